// File: rtl/psum_pkg.sv
// Shared definitions for the psum collector slice.
//   - state_e   : collector FSM states
//   - PSUM_W    : width of the incoming partial-sum word
//   - COL_W     : width of one column field in split mode
//   - ACC_W_DEF : default accumulator lane width
//   - ext()     : sign/zero extension of a column or full psum to EXT_W bits
package psum_pkg;

  localparam int unsigned PSUM_W    = 18;
  localparam int unsigned COL_W     = PSUM_W / 2;
  localparam int unsigned ACC_W_DEF = 24;
  // Wide enough for a total-mode accumulator up to 2*31 bits.
  localparam int unsigned EXT_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // col=1 extends v[COL_W-1:0], col=0 extends the whole PSUM_W word.
  function automatic logic [EXT_W-1:0] ext(input logic [PSUM_W-1:0] v, input logic col,
                                           input logic sgn);
    logic fill;
    if (col) begin
      fill = sgn & v[COL_W-1];
      return {{(EXT_W-COL_W){fill}}, v[COL_W-1:0]};
    end
    fill = sgn & v[PSUM_W-1];
    return {{(EXT_W-PSUM_W){fill}}, v};
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Bundle of the collector's three handshakes: job configuration, psum stream from the
// fusion unit and result writeback.
//   master : array controller / writeback side (drives cfg, psum, acc_ready)
//   slave  : the collector
interface psum_collector_if
  import psum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = 8
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_len;
  logic               cfg_split;
  logic               cfg_sign;
  logic [PSUM_W-1:0]  psum_in;
  logic               psum_valid;
  logic               psum_ready;
  logic [2*ACC_W-1:0] acc_out;
  logic               acc_valid;
  logic               acc_ready;
  logic               sat_flag;

  modport master (
    output cfg_valid, cfg_len, cfg_split, cfg_sign, psum_in, psum_valid, acc_ready,
    input  cfg_ready, psum_ready, acc_out, acc_valid, sat_flag
  );

  modport slave (
    input  cfg_valid, cfg_len, cfg_split, cfg_sign, psum_in, psum_valid, acc_ready,
    output cfg_ready, psum_ready, acc_out, acc_valid, sat_flag
  );

endinterface

// File: rtl/psum_lane_add.sv
// One accumulator lane: acc + addend + cin with overflow detection.
// Optional saturation is compiled in with the macro PSUM_SAT_EN; otherwise the sum wraps
// and the sat outputs are 0.
//   acc, addend : lane operands (addend already extended to W)
//   cin         : carry in (low lane's carry when chained for total mode)
//   sgn         : operands are two's complement
//   sat_ok      : this lane is the top of its accumulator and may clamp
//   sum, cout   : result and raw carry out
//   sat_pos/neg : the result was clamped to the upper/lower bound
module psum_lane_add #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  input  logic         cin,
  input  logic         sgn,
  input  logic         sat_ok,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         sat_pos,
  output logic         sat_neg
);

  logic [W:0] raw;
  logic       ovf_pos;
  logic       ovf_neg;

  always_comb begin
    raw = {1'b0, acc} + {1'b0, addend} + {{W{1'b0}}, cin};
    if (sgn) begin
      // Carry-in is folded into raw, so the sign rule stays exact for chained lanes.
      ovf_pos = ~acc[W-1] & ~addend[W-1] &  raw[W-1];
      ovf_neg =  acc[W-1] &  addend[W-1] & ~raw[W-1];
    end else begin
      ovf_pos = raw[W];
      ovf_neg = 1'b0;
    end
  end

  assign cout = raw[W];

`ifdef PSUM_SAT_EN
  always_comb begin
    sat_pos = sat_ok & ovf_pos;
    sat_neg = sat_ok & ovf_neg;
    if (sat_pos) begin
      sum = sgn ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
    end else if (sat_neg) begin
      sum = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum = raw[W-1:0];
    end
  end
`else
  logic unused_sat;
  assign unused_sat = ^{sat_ok, ovf_pos, ovf_neg};
  assign sat_pos    = 1'b0;
  assign sat_neg    = 1'b0;
  assign sum        = raw[W-1:0];
`endif

endmodule

// File: rtl/psum_collector.sv
// Receive end of the fusion-unit partial-sum interface. Accumulates cfg_len psum beats
// either as two column lanes (split) or as one 2*ACC_W total, then offers the result on
// a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : psum_collector_if.slave (cfg_*, psum_*, acc_*, sat_flag)
// Macro PSUM_SAT_EN: saturating adds with a sticky sat_flag; undefined, adds wrap and
// sat_flag stays 0.
module psum_collector
  import psum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  psum_collector_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, len_q;
  logic               split_q, sign_q, sat_q;
  logic [ACC_W-1:0]   lane0_q, lane1_q;
  logic [2*ACC_W-1:0] acc_out_q;

  logic [PSUM_W-1:0]  hi_col_in;
  logic [EXT_W-1:0]   ext_lo_col, ext_hi_col, ext_tot;
  logic [ACC_W-1:0]   add0, add1;
  logic [ACC_W-1:0]   sum0, sum1, new0;
  logic               cout0, unused_cout1;
  logic               sp0, sn0, sp1, sn1;
  logic               beat_sat, last_beat, cfg_take, beat_take;
  logic               unused_ext;

  // Operand extension: split uses two columns, total uses the whole word across lanes.
  assign hi_col_in  = {{COL_W{1'b0}}, bus.psum_in[PSUM_W-1:COL_W]};
  assign ext_lo_col = ext(bus.psum_in, 1'b1, sign_q);
  assign ext_hi_col = ext(hi_col_in, 1'b1, sign_q);
  assign ext_tot    = ext(bus.psum_in, 1'b0, sign_q);
  assign unused_ext = ^{ext_lo_col[EXT_W-1:ACC_W], ext_hi_col[EXT_W-1:ACC_W],
                        ext_tot[EXT_W-1:2*ACC_W]};

  assign add0 = split_q ? ext_lo_col[ACC_W-1:0] : ext_tot[ACC_W-1:0];
  assign add1 = split_q ? ext_hi_col[ACC_W-1:0] : ext_tot[2*ACC_W-1:ACC_W];

  psum_lane_add #(.W(ACC_W)) u_lane0 (
    .acc     (lane0_q),
    .addend  (add0),
    .cin     (1'b0),
    .sgn     (sign_q),
    .sat_ok  (split_q),
    .sum     (sum0),
    .cout    (cout0),
    .sat_pos (sp0),
    .sat_neg (sn0)
  );

  // In total mode lane1 is the high half, fed by lane0's carry.
  psum_lane_add #(.W(ACC_W)) u_lane1 (
    .acc     (lane1_q),
    .addend  (add1),
    .cin     (~split_q & cout0),
    .sgn     (sign_q),
    .sat_ok  (1'b1),
    .sum     (sum1),
    .cout    (unused_cout1),
    .sat_pos (sp1),
    .sat_neg (sn1)
  );

  // A total-mode clamp must also force the low half to the matching bound.
  always_comb begin
    new0 = sum0;
    if (!split_q && sp1) begin
      new0 = {ACC_W{1'b1}};
    end else if (!split_q && sn1) begin
      new0 = {ACC_W{1'b0}};
    end
  end

  assign beat_sat  = sp0 | sn0 | sp1 | sn1;
  assign last_beat = (count_q == len_q - 1'b1);
  assign cfg_take  = (state_q == IDLE) && bus.cfg_valid;
  assign beat_take = (state_q == ACCUM) && bus.psum_valid;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cfg_valid) state_d = ACCUM;
      ACCUM:   if (bus.psum_valid && last_beat) state_d = DRAIN;
      DRAIN:   if (bus.acc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from state
  always_comb begin
    bus.cfg_ready  = 1'b0;
    bus.psum_ready = 1'b0;
    bus.acc_valid  = 1'b0;
    unique case (state_q)
      IDLE:    bus.cfg_ready  = 1'b1;
      ACCUM:   bus.psum_ready = 1'b1;
      DRAIN:   bus.acc_valid  = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      len_q     <= '0;
      split_q   <= 1'b0;
      sign_q    <= 1'b0;
      sat_q     <= 1'b0;
      lane0_q   <= '0;
      lane1_q   <= '0;
      acc_out_q <= '0;
    end else if (cfg_take) begin
      len_q   <= (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
      split_q <= bus.cfg_split;
      sign_q  <= bus.cfg_sign;
      count_q <= '0;
      sat_q   <= 1'b0;
      lane0_q <= '0;
      lane1_q <= '0;
    end else if (beat_take) begin
      lane0_q <= new0;
      lane1_q <= sum1;
      count_q <= count_q + 1'b1;
      if (beat_sat) begin
        sat_q <= 1'b1;
      end
      if (last_beat) begin
        acc_out_q <= {sum1, new0};
      end
    end
  end

  assign bus.acc_out  = acc_out_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Receive end of the fusion-unit partial-sum interface.
- Consumes the registered 18-bit psum stream that a fusion unit forwards each cycle.
- Accumulates a configured number of beats, in either split-column mode (two 9-bit column sums) or total mode (one 18-bit sum).
- Presents the wide accumulated result to the output writeback path through a valid/ready handshake.

Parameters:
- PSUM_W, 18, input psum width; split mode treats it as two PSUM_W/2 column fields.
- ACC_W, 24, width of each split-mode accumulator lane; total mode uses 2*ACC_W.
- CNT_W, 8, width of the beat-count configuration.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- cfg_valid  in  1  job configuration valid
- cfg_ready  out  1  collector idle, configuration accepted
- cfg_len  in  CNT_W  number of psum beats per job; 0 is treated as 1
- cfg_split  in  1  1: psum is {col2,col1}, accumulated as two lanes; 0: one total
- cfg_sign  in  1  1: psum fields are two's complement; 0: unsigned
- psum_in  in  PSUM_W  partial sum from the fusion unit
- psum_valid  in  1  psum_in valid this cycle
- psum_ready  out  1  collector consuming psums
- acc_out  out  2*ACC_W  result; split: {lane1,lane0}; total: one value
- acc_valid  out  1  result valid
- acc_ready  in  1  downstream accepts result
- sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset values:
  - State is IDLE; count and accumulators are 0.
  - acc_out=0, acc_valid=0, psum_ready=0, sat_flag=0.
  - cfg_ready=1 from the first cycle after reset.
- cfg_ready and psum_ready are decoded from state (IDLE and ACCUM respectively), not registered separately.
- IDLE:
  - On cfg_valid: latch len (0 becomes 1), split and sign; clear both lanes, count and sat_flag; go to ACCUM.
- ACCUM:
  - Each cycle with psum_valid adds one beat and increments count; cycles without psum_valid hold state.
  - The beat where count==len-1 writes the final sum into the acc_out register and moves to DRAIN.
  - acc_valid rises the cycle after the final beat, so latency from last beat to acc_valid is 1 cycle.
- DRAIN:
  - acc_valid held high; acc_out stable until acc_ready.
  - The handshake cycle returns to IDLE, and acc_valid drops the next cycle.
  - cfg_ready is asserted in the cycle after the handshake.
- psum_valid outside ACCUM is ignored and dropped. The array controller only drives psum_valid during ACCUM, because the fusion unit has no backpressure.
- Split-mode arithmetic:
  - lane0 += ext(psum_in[8:0]); lane1 += ext(psum_in[17:9]).
  - ext is sign-extension to ACC_W when sign=1, zero-extension otherwise.
  - acc_out = {lane1, lane0}.
- Total-mode arithmetic:
  - A single 2*ACC_W accumulator adds ext(psum_in[17:0]).
  - lane0/lane1 storage is reused as its low and high halves.
- Overflow wraps modulo the lane width unless PSUM_SAT_EN is defined.
- rst mid-job discards the partial accumulation and any pending result; no acc_valid is produced for the aborted job.
- Simultaneous cfg_valid and psum_valid in IDLE: the config is taken, and that psum beat is not counted.

Optional Feature:
- Macro PSUM_SAT_EN.
- Defined:
  - Each add saturates at its lane bounds. Signed bounds are [-2^(W-1), 2^(W-1)-1]; unsigned bounds are [0, 2^W-1], where W is ACC_W per split lane or 2*ACC_W in total mode.
  - Any clamp sets sat_flag. sat_flag stays set until the next cfg accept or rst.
- Undefined: wrap-around arithmetic; sat_flag is tied to 0.

Decomposition:
- Shared package psum_pkg holds:
  - state enum {IDLE, ACCUM, DRAIN};
  - PSUM_W and column width PSUM_W/2;
  - default ACC_W;
  - an extension helper function.
- One natural sub-module, psum_lane_add: one lane's extend+add with optional saturation, used twice in split mode and chained for total mode.

Test Plan:
- Split signed, len=2, beats {9'h1FF,9'h002} then {9'h003,9'h1FE} -> lane1=2, lane0=0; acc_out={24'd2,24'd0}; acc_valid 1 cycle after beat 2.
- Total unsigned, len=3, psum 18'h3FFFF x3 with an idle cycle between beats 1 and 2 -> acc_out=48'h0000000BFFFD.
- Total signed, cfg_len=0, single psum 18'h20000 -> treated as len 1; acc_out=48'hFFFFFFFE0000.
- Backpressure: acc_ready low for 5 cycles after acc_valid -> acc_out stable, psum_ready=0, cfg_ready=0; raise acc_ready -> acc_valid=0 and cfg_ready=1 the next cycle.
- rst after 2 of 4 beats -> all outputs 0 and cfg_ready=1 next cycle; a new len=1 job with psum 18'h00005 (total, unsigned) gives acc_out=5.
- ACC_W=10, split signed, PSUM_SAT_EN, lane0 beats 9'h0FF x3 -> lane0=511, sat_flag=1; without the macro -> lane0=10'h2FD (-259), sat_flag=0.
